fetch_controller: RTL and testbench

Sequences instruction fetch for the RISC-V core. It owns the program counter, issues one word-aligned request at a time to instruction memory over a valid/ready handshake, and holds each returned instruction for decode under a second valid/ready handshake. It also applies branch/jump redirects, squashing any fetch already in flight, and supports a halt input that pauses fetch.

---
 rtl/fetch_controller.sv | 132 +++++++++++++
 tb/tb_fetch_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a
// time, and holds each returned word for decode until it is accepted.
module fetch_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic            r_inst_valid, w_inst_valid_n;
  logic [XLEN-1:0] r_inst_data, w_inst_data_n;
  logic [XLEN-1:0] r_inst_pc, w_inst_pc_n;
  logic            r_squash, w_squash_n;
  logic [31:0]     r_count, w_count_n;
  logic [XLEN-1:0] w_tgt;
  logic            w_req_fire;

  assign w_tgt = redirect_pc & ~XLEN'(3);

  // Gated by reset so no request is visible while held in reset.
  assign imem_req_valid = reset & (r_state == S_REQ)
                        & ~halt & ~redirect_valid;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign imem_req_addr = r_pc;
  assign pc            = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst_data     = r_inst_data;
  assign inst_pc       = r_inst_pc;
  assign fetch_count   = r_count;

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_inst_valid_n = r_inst_valid;
    w_inst_data_n  = r_inst_data;
    w_inst_pc_n    = r_inst_pc;
    w_squash_n     = r_squash;
    w_count_n      = r_count;
    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_n = w_tgt;
        end else if (w_req_fire) begin
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_squash_n = 1'b0;
          if (redirect_valid) begin
            w_pc_n    = w_tgt;
            w_state_n = S_REQ;
          end else if (r_squash) begin
            w_state_n = S_REQ;
          end else begin
            w_inst_data_n  = imem_resp_data;
            w_inst_pc_n    = r_pc;
            w_pc_n         = r_pc + XLEN'(4);
            w_inst_valid_n = 1'b1;
            w_state_n      = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Response still owed by memory; mark it stale.
          w_pc_n     = w_tgt;
          w_squash_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          w_count_n      = r_count + 32'd1;
          w_inst_valid_n = 1'b0;
          w_state_n      = S_REQ;
          if (redirect_valid) begin
            w_pc_n = w_tgt;
          end
        end else if (redirect_valid) begin
          w_inst_valid_n = 1'b0;
          w_pc_n         = w_tgt;
          w_state_n      = S_REQ;
        end
      end
      default: begin
        w_state_n = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
      r_squash     <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_inst_valid <= w_inst_valid_n;
      r_inst_data  <= w_inst_data_n;
      r_inst_pc    <= w_inst_pc_n;
      r_squash     <= w_squash_n;
      r_count      <= w_count_n;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: table vectors, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        rdy;
  logic [31:0] req_addr;
  logic        rv;
  logic [31:0] rd;
  logic        iv;
  logic        irdy;
  logic [31:0] idata;
  logic [31:0] ipc;
  logic        redir;
  logic [31:0] rpc;
  logic        hlt;
  logic [31:0] pc;
  logic [31:0] cnt;

  int n_vec = 0;
  int n_bad = 0;

  fetch_controller #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .imem_req_valid  (req_valid),
    .imem_req_ready  (rdy),
    .imem_req_addr   (req_addr),
    .imem_resp_valid (rv),
    .imem_resp_data  (rd),
    .inst_valid      (iv),
    .inst_ready      (irdy),
    .inst_data       (idata),
    .inst_pc         (ipc),
    .redirect_valid  (redir),
    .redirect_pc     (rpc),
    .halt            (hlt),
    .pc              (pc),
    .fetch_count     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        irdy;
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic a_rdy, input logic a_rv,
                        input logic [31:0] a_rd, input logic a_irdy,
                        input logic a_redir, input logic [31:0] a_rpc,
                        input logic a_hlt);
    @(negedge clk);
    rdy   = a_rdy;
    rv    = a_rv;
    rd    = a_rd;
    irdy  = a_irdy;
    redir = a_redir;
    rpc   = a_rpc;
    hlt   = a_hlt;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy = 0; rv = 0; rd = 0; irdy = 0; redir = 0; rpc = 0; hlt = 0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_iv", iv, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_req", req_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state
  logic [31:0] m_pc, m_cnt, maddr, p_data, p_pc;
  logic        mpend, p_hold, acc;
  int          mlat;

  initial begin
    rst_n = 1'b0;
    rdy = 0; rv = 0; rd = 0; irdy = 0; redir = 0; rpc = 0; hlt = 0;
    tbl[0] = '{1,0,0,1,0,0,0, 1,32'h0,0,0,0,0};
    tbl[1] = '{1,1,32'h00000013,1,0,0,0, 0,32'h0,0,0,0,0};
    tbl[2] = '{1,0,0,1,0,0,0, 0,32'h4,1,32'h0,32'h00000013,0};
    tbl[3] = '{1,0,0,1,0,0,0, 1,32'h4,0,0,0,1};
    tbl[4] = '{1,1,32'h00100093,1,0,0,0, 0,32'h4,0,0,0,1};
    tbl[5] = '{1,0,0,1,0,0,0, 0,32'h8,1,32'h4,32'h00100093,1};
    tbl[6] = '{1,0,0,1,0,0,0, 1,32'h8,0,0,0,2};
    tbl[7] = '{1,1,32'h00200113,1,0,0,0, 0,32'h8,0,0,0,2};
    tbl[8] = '{1,0,0,1,0,0,0, 0,32'hC,1,32'h8,32'h00200113,2};
    tbl[9] = '{0,0,0,1,0,0,0, 1,32'hC,0,0,0,3};

    @(negedge clk);
    do_reset();
    chk("rst_idata", idata, 0);
    chk("rst_ipc", ipc, 0);

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].irdy,
             tbl[i].redir, tbl[i].rpc, tbl[i].hlt);
      chk("tbl_req", req_valid, tbl[i].e_req);
      chk("tbl_pc", pc, tbl[i].e_pc);
      chk("tbl_iv", iv, tbl[i].e_iv);
      chk("tbl_cnt", cnt, tbl[i].e_cnt);
      if (tbl[i].e_iv) begin
        chk("tbl_ipc", ipc, tbl[i].e_ipc);
        chk("tbl_idata", idata, tbl[i].e_idata);
      end
    end

    // Redirect while waiting: stale response must be discarded
    set_in(1,0,0,0,0,0,0);
    chk("wr_req", req_valid, 1);
    chk("wr_addr", req_addr, 32'hC);
    set_in(0,0,0,0,1,32'h102,0);
    chk("wr_req_redir", req_valid, 0);
    set_in(0,0,0,0,0,0,0);
    chk("wr_pc", pc, 32'h100);
    chk("wr_iv0", iv, 0);
    set_in(0,0,0,0,0,0,0);
    chk("wr_iv1", iv, 0);
    set_in(0,1,32'hDEADBEEF,0,0,0,0);
    chk("wr_iv2", iv, 0);
    set_in(1,0,0,0,0,0,0);
    chk("wr_iv3", iv, 0);
    chk("wr_req2", req_valid, 1);
    chk("wr_addr2", req_addr, 32'h100);
    set_in(0,1,32'h11111111,1,0,0,0);
    set_in(0,0,0,1,0,0,0);
    chk("wr_iv4", iv, 1);
    chk("wr_ipc", ipc, 32'h100);
    chk("wr_idata", idata, 32'h11111111);
    chk("wr_cnt", cnt, 3);

    // Redirect coincident with response
    set_in(1,0,0,0,0,0,0);
    chk("rr_addr", req_addr, 32'h104);
    chk("rr_cnt", cnt, 4);
    set_in(1,1,32'h22222222,0,1,32'h200,0);
    chk("rr_req", req_valid, 0);
    set_in(0,0,0,0,0,0,0);
    chk("rr_iv", iv, 0);
    chk("rr_req2", req_valid, 1);
    chk("rr_addr2", req_addr, 32'h200);
    chk("rr_cnt2", cnt, 4);

    // Decode stall in HOLD then redirect drops the instruction
    set_in(1,0,0,0,0,0,0);
    set_in(0,1,32'hAAAA5555,0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      set_in(1,0,0,0,0,0,0);
      chk("st_iv", iv, 1);
      chk("st_ipc", ipc, 32'h200);
      chk("st_idata", idata, 32'hAAAA5555);
      chk("st_req", req_valid, 0);
    end
    set_in(0,0,0,0,1,32'h300,0);
    set_in(0,0,0,0,0,0,0);
    chk("st_iv2", iv, 0);
    chk("st_cnt", cnt, 4);
    chk("st_addr", req_addr, 32'h300);

    // Halt in REQ, then halt during WAIT
    for (int k = 0; k < 4; k++) begin
      set_in(1,0,0,0,0,0,1);
      chk("h_req", req_valid, 0);
    end
    set_in(1,0,0,0,0,0,0);
    chk("h_req2", req_valid, 1);
    chk("h_addr", req_addr, 32'h300);
    set_in(0,0,0,0,0,0,1);
    set_in(0,1,32'h33333333,0,0,0,1);
    set_in(0,0,0,1,0,0,1);
    chk("h_iv", iv, 1);
    chk("h_ipc", ipc, 32'h300);
    chk("h_idata", idata, 32'h33333333);
    set_in(0,0,0,0,0,0,0);
    chk("h_cnt", cnt, 5);

    // PC wrap at top of address space
    set_in(0,0,0,0,1,32'hFFFFFFFF,0);
    set_in(1,0,0,0,0,0,0);
    chk("wp_addr", req_addr, 32'hFFFFFFFC);
    set_in(0,1,32'h44444444,0,0,0,0);
    set_in(0,0,0,1,0,0,0);
    chk("wp_ipc", ipc, 32'hFFFFFFFC);
    chk("wp_pc", pc, 32'h0);
    set_in(0,0,0,0,0,0,0);
    chk("wp_addr2", req_addr, 32'h0);
    chk("wp_cnt", cnt, 6);

    // Asynchronous reset while waiting at 0x40
    set_in(0,0,0,0,1,32'h40,0);
    set_in(1,0,0,0,0,0,0);
    chk("ar_addr", req_addr, 32'h40);
    set_in(0,0,0,0,0,0,0);
    do_reset();
    set_in(0,0,0,0,0,0,0);
    chk("ar_req", req_valid, 1);
    chk("ar_addr2", req_addr, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    m_pc = 0; m_cnt = 0; mpend = 0; mlat = 0; maddr = 0;
    p_hold = 0; p_data = 0; p_pc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rv    = mpend && (mlat == 0);
      rd    = rv ? memf(maddr) : $urandom;
      rdy   = ($urandom % 4) != 0;
      irdy  = ($urandom % 3) != 0;
      redir = ($urandom % 12) == 0;
      rpc   = $urandom;
      hlt   = ($urandom % 8) == 0;
      #1;
      chk("r_cnt", cnt, m_cnt);
      chk("r_gate", {31'b0, req_valid & (hlt | redir)}, 0);
      if (p_hold) begin
        chk("r_hold_iv", iv, 1);
        chk("r_hold_data", idata, p_data);
        chk("r_hold_pc", ipc, p_pc);
      end
      acc = req_valid && rdy;
      if (acc) begin
        chk("r_req_addr", req_addr, m_pc);
        chk("r_outstanding", {31'b0, mpend}, 0);
      end
      if (iv && irdy) begin
        chk("r_ipc", ipc, m_pc);
        chk("r_idata", idata, memf(m_pc));
        m_cnt = m_cnt + 1;
        m_pc  = m_pc + 4;
      end
      if (redir) m_pc = {rpc[31:2], 2'b00};
      p_hold = iv && !irdy && !redir;
      p_data = idata;
      p_pc   = ipc;
      if (rv) mpend = 0;
      else if (mpend) mlat--;
      if (acc) begin
        mpend = 1;
        mlat  = $urandom % 4;
        maddr = req_addr;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
